if_fetch_stage: RTL

- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and a direct-mapped instruction cache.
- On a cache miss it fetches one 32-bit word from the memory controller using a request/done handshake.
- Delivers (pc, instruction) pairs to IF/ID, inserts bubbles (instruction 0) while waiting, and redirects the PC on branch signals from EX.

---
 rtl/if_pkg.sv | 25 ++
 rtl/if_fetch_stage_if.sv | 23 ++
 rtl/if_fetch_stage_icache_dm.sv | 56 +++++
 rtl/if_fetch_stage.sv | 122 ++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage and its cache.
package if_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } if_state_e;

  localparam logic [31:0] BUBBLE_INSTR  = 32'h0;
  localparam int          IDX_W_DEFAULT = 8;
  localparam int          TAG_W         = 30 - IDX_W_DEFAULT;

  // Tag width for a given index width: word address bits left above the index.
  function automatic int tag_width(input int idx_w);
    return 30 - idx_w;
  endfunction

  // Observation bundle: FSM state, pending-redirect flag and the live PC.
  typedef struct packed {
    if_state_e   state;
    logic        discard;
    logic [31:0] pc;
  } if_dbg_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-side memory bus between the fetch stage (master) and the memory controller (slave).
interface if_fetch_stage_if;
  // mem_req rises with a word-aligned mem_addr and both hold until the cycle mem_done=1;
  // mem_instr is only meaningful in that cycle, and mem_req drops on the following edge.
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_instr;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_done,
    input  mem_instr
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_done,
    output mem_instr
  );
endinterface

// File: rtl/if_fetch_stage_icache_dm.sv
// Direct-mapped, one-word-per-line instruction cache with combinational lookup.
module icache_dm
  import if_pkg::*;
#(
  parameter int LINES = 256,
  parameter int IDX_W = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] rd_addr,
  output logic        hit,
  output logic [31:0] rdata,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);

  localparam int TW = tag_width(IDX_W);

  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [TW-1:0]    rd_tag;
  logic [TW-1:0]    wr_tag;
  logic             unused_low_bits;

  assign rd_idx = rd_addr[IDX_W+1:2];
  assign rd_tag = rd_addr[31:IDX_W+2];
  assign wr_idx = wr_addr[IDX_W+1:2];
  assign wr_tag = wr_addr[31:IDX_W+2];
  // Addresses are always word aligned; the byte offset carries no information.
  assign unused_low_bits = ^{rd_addr[1:0], wr_addr[1:0]};

  assign hit   = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rdata = data_q[rd_idx];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data need no reset: a line is never read as a hit until its valid bit is set.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, looks up the I-cache, fetches misses from memory
// and hands (pc, instruction) pairs to IF/ID, inserting bubbles while it waits.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter int          ICACHE_LINES = 256,
  parameter int          IDX_W        = 8,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [5:0]            stall_in,
  input  logic                  branch_or_not,
  input  logic [31:0]           branch_target,
  if_fetch_stage_if.master      mem,
  output logic                  stall_req,
  output logic [31:0]           output_pc,
  output logic [31:0]           output_instru,
  output if_dbg_t               dbg_out
);

  if_state_e   state_q;
  logic [31:0] pc_q;
  logic        discard_q;
  logic        mem_req_q;
  logic [31:0] mem_addr_q;

  logic        hit;
  logic [31:0] hit_word;
  logic        fill_en;
  logic        unused_stall_bits;

  assign unused_stall_bits = ^stall_in[5:1];

  // Every completed fetch fills its line, even when the word itself is discarded.
  assign fill_en = rdy_in && !rst_in && (state_q == WAIT) && mem.mem_done;

  icache_dm #(
    .LINES (ICACHE_LINES),
    .IDX_W (IDX_W)
  ) u_icache (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rd_addr (pc_q),
    .hit     (hit),
    .rdata   (hit_word),
    .wr_en   (fill_en),
    .wr_addr (mem_addr_q),
    .wr_data (mem.mem_instr)
  );

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign dbg_out      = {state_q, discard_q, pc_q};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      discard_q     <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= 32'h0;
      stall_req     <= 1'b0;
      output_pc     <= 32'h0;
      output_instru <= BUBBLE_INSTR;
    end else if (rdy_in) begin
      case (state_q)
        IDLE: begin
          if (branch_or_not) begin
            pc_q          <= branch_target;
            output_pc     <= 32'h0;
            output_instru <= BUBBLE_INSTR;
          end else if (stall_in[0]) begin
            // Hold everything so IF/ID keeps seeing the same pair.
          end else if (hit) begin
            output_pc     <= pc_q;
            output_instru <= hit_word;
            pc_q          <= pc_q + 32'd4;
          end else begin
            mem_req_q     <= 1'b1;
            mem_addr_q    <= pc_q;
            stall_req     <= 1'b1;
            output_pc     <= 32'h0;
            output_instru <= BUBBLE_INSTR;
            state_q       <= WAIT;
          end
        end

        WAIT: begin
          output_pc     <= 32'h0;
          output_instru <= BUBBLE_INSTR;
          if (!mem.mem_done) begin
            // The request stays on mem_addr; a redirect only records where to go next.
            if (branch_or_not) begin
              discard_q <= 1'b1;
              pc_q      <= branch_target;
            end
          end else begin
            mem_req_q <= 1'b0;
            stall_req <= 1'b0;
            state_q   <= IDLE;
            if (discard_q || branch_or_not) begin
              // pc_q already holds the latched target unless a branch arrives now.
              discard_q <= 1'b0;
              if (branch_or_not) begin
                pc_q <= branch_target;
              end
            end else if (!stall_in[0]) begin
              output_pc     <= mem_addr_q;
              output_instru <= mem.mem_instr;
              pc_q          <= mem_addr_q + 32'd4;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
